stepper_sweep_ctrl: RTL and testbench
=====================================

# stepper_sweep_ctrl

Parametrised unipolar stepper sequencer for the kitchen-helper motor channels: wave, two-phase full-step or half-step drive, configurable step rate, steps per sweep and number of back-and-forth sweeps. It runs on the 50 MHz system clock using an internal step-tick prescaler, with no derived clock. It sits between the top-level controller (start/stop/done handshake) and the four-pin motor driver (coil outputs).

## Interface
- STEP_DIV, 500000: clk cycles per step (10 ms at 50 MHz); ≥2
- STEP_W, 8: width of steps_i and step_pos_o
- SWEEP_W, 4: width of sweeps_i
- HOLD_TORQUE, 0: 1 = keep last coil pattern after completion; 0 = de-energise
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  start request, sampled in IDLE only
- stop_i  in  1  abort; priority over everything except reset
- mode_i  in  2  0 wave, 1 full (two-phase), 2 half-step, 3 reserved (treated as 0); latched at start
- dir_i  in  1  initial direction, 1 = forward; latched at start
- steps_i  in  STEP_W  phase advances per sweep; latched at start
- sweeps_i  in  SWEEP_W  number of sweeps; direction reverses between sweeps; latched at start
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle completion pulse
- coil_o  out  4  {B', A', B, A} coil drive
- step_pos_o  out  STEP_W  steps completed in current sweep

## Operation
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Wave uses even indices, full uses odd indices, half uses all.
- Forward adds the increment (2 for wave/full, 1 for half) to the index mod 8; reverse subtracts it mod 8.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 with stop_i=0 latches the inputs.
  - If steps_i=0 or sweeps_i=0: go to DONE with no motion.
  - Otherwise: go to RUN, set index to 0 (wave/half) or 1 (full), energise coil_o, clear the prescaler, step_pos_o and the sweep count.
- RUN: the prescaler counts 0..STEP_DIV-1. At terminal count:
  - advance the index;
  - step_pos_o+1;
  - when step_pos_o reaches the latched step count, clear step_pos_o, increment the sweep count and toggle direction;
  - when the sweep count reaches the latched sweep count, go to DONE.
- DONE: one cycle, done_o=1, then IDLE. In IDLE, coil_o is 0 if HOLD_TORQUE=0, otherwise it holds the last pattern.
- stop_i in RUN or DONE: next cycle IDLE, coil_o=0 regardless of HOLD_TORQUE, done_o=0, step_pos_o=0.
- Start in RUN or DONE is ignored. stop_i and start_i together in IDLE: start is ignored. stop_i coinciding with the final step: stop wins, no done_o.
- Reset mid-operation: all outputs return to reset values immediately; latched configuration is cleared.

## Timing
- Reset values: busy_o=0, done_o=0, coil_o=0000, step_pos_o=0, state IDLE, prescaler 0.
- All outputs are registered.
- start_i at cycle T: busy_o=1 and coil_o=first pattern at T+1. First advance is visible at T+1+STEP_DIV; step k is visible at T+1+k·STEP_DIV.
- Final advance at cycle F: coil_o shows the final pattern, busy_o=0 and done_o=1 at F. The coil_o de-energise (HOLD_TORQUE=0) happens at F+1.
- Zero-length start at T: done_o=1 at T+1, busy_o stays 0, coil_o unchanged.
- The prescaler counts only in RUN; it has no leftover count across starts.
- Direction reversal takes effect at the next advance after the sweep boundary; there is no extra dwell cycle.

## Structure
- Package stepper_pkg:
  - phase table constant (8×4);
  - mode encodings (MODE_WAVE, MODE_FULL, MODE_HALF);
  - state encodings;
  - index increment function of mode.
- Sub-module step_prescaler: enable/clear inputs, tick output, counter width $clog2(STEP_DIV).
- FSM, index, step/sweep counters and output registers live in stepper_sweep_ctrl.

## Test plan
All scenarios use STEP_DIV=4.
- Reset mid-RUN (mode 1, steps 8, sweeps 1) → coil_o=0000 and busy_o=0 asynchronously, no done_o; a new start afterwards behaves normally.
- Wave, dir 1, steps 4, sweeps 1: start at T → coil_o 0001@T+1, 0010@T+5, 0100@T+9, 1000@T+13, 0001@T+17 with done_o@T+17, coil_o=0000@T+18.
- Half, dir 0, steps 3, sweeps 2, HOLD_TORQUE=1 → 0001, 1001, 1000, 1100, then reversal 1000, 1001, 0001. done_o after 6 advances, coil_o holds 0001.
- Full, dir 1, steps 5, stop_i asserted after 2 advances → coil_o=0000 and busy_o=0 next cycle, done_o never pulses, step_pos_o=0.
- steps_i=0, sweeps_i=3 → done_o one cycle after start, busy_o never high, coil_o stays 0000.
- start_i with stop_i in the same cycle, and start_i during RUN → both ignored; the running sequence and its counts are unchanged.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg: phase table, mode/state encodings and index helpers for the stepper sequencer
package stepper_pkg;
  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0][3:0] PHASE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                       4'b0110, 4'b0010, 4'b0011, 4'b0001};
  function automatic logic [2:0] phase_inc(input logic [1:0] mode);
    return mode == MODE_HALF ? 3'd1 : 3'd2;
  endfunction
  function automatic logic [2:0] phase_start(input logic [1:0] mode);
    return mode == MODE_FULL ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: one-cycle tick every DIV enabled cycles, restarts from zero when disabled or cleared
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || !en || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/stepper_sweep_ctrl.sv
// stepper_sweep_ctrl: unipolar stepper sequencer with wave/full/half drive and back-and-forth sweeps
module stepper_sweep_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_DIV    = 500000,
  parameter int STEP_W      = 8,
  parameter int SWEEP_W     = 4,
  parameter int HOLD_TORQUE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic               dir_i,
  input  logic [STEP_W-1:0]  steps_i,
  input  logic [SWEEP_W-1:0] sweeps_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [3:0]         coil_o,
  output logic [STEP_W-1:0]  step_pos_o
);
  logic [1:0] state, mode_q, mode_n;
  logic dir_q, tick, start_ok, zero_len, last_step, last_sweep;
  logic [STEP_W-1:0] steps_q;
  logic [SWEEP_W-1:0] sweeps_q, sweep_cnt;
  logic [2:0] idx, nidx;
  always_comb begin
    mode_n = mode_i == 2'd3 ? MODE_WAVE : mode_i;
    start_ok = state == S_IDLE && start_i && !stop_i;
    zero_len = steps_i == '0 || sweeps_i == '0;
    nidx = dir_q ? idx + phase_inc(mode_q) : idx - phase_inc(mode_q);
    last_step = step_pos_o + 1'b1 == steps_q;
    last_sweep = sweep_cnt + 1'b1 == sweeps_q;
  end
  step_prescaler #(.DIV(STEP_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == S_RUN),
    .clr  (start_ok),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      mode_q <= MODE_WAVE;
      dir_q <= 1'b0;
      steps_q <= '0;
      sweeps_q <= '0;
      sweep_cnt <= '0;
      idx <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      coil_o <= 4'b0;
      step_pos_o <= '0;
    end else if (stop_i && state != S_IDLE) begin
      state <= S_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      coil_o <= 4'b0;
      step_pos_o <= '0;
    end else if (state == S_IDLE) begin
      done_o <= 1'b0;
      if (start_ok) begin
        mode_q <= mode_n;
        dir_q <= dir_i;
        steps_q <= steps_i;
        sweeps_q <= sweeps_i;
        sweep_cnt <= '0;
        step_pos_o <= '0;
        if (zero_len) begin
          state <= S_DONE;
          done_o <= 1'b1;
        end else begin
          state <= S_RUN;
          busy_o <= 1'b1;
          idx <= phase_start(mode_n);
          coil_o <= PHASE[phase_start(mode_n)];
        end
      end
    end else if (state == S_RUN) begin
      if (tick) begin
        idx <= nidx;
        coil_o <= PHASE[nidx];
        if (last_step) begin
          step_pos_o <= '0;
          sweep_cnt <= sweep_cnt + 1'b1;
          dir_q <= !dir_q;
          if (last_sweep) begin
            state <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end else step_pos_o <= step_pos_o + 1'b1;
      end
    end else begin
      state <= S_IDLE;
      done_o <= 1'b0;
      coil_o <= HOLD_TORQUE != 0 ? coil_o : 4'b0;
    end
endmodule

// File: tb/tb_stepper_sweep_ctrl.sv
// tb_stepper_sweep_ctrl: directed and random sweeps on de-energising and holding instances against a trace model
module tb_stepper_sweep_ctrl;
  localparam int DIV = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] steps = 8'd0;
  logic [3:0] sweeps = 4'd0;
  logic busy [2], done [2];
  logic [3:0] coil [2];
  logic [7:0] pos [2];
  int n_cmp = 0, n_bad = 0;
  int mst = 0, j = 0, m_mode = 0, m_dir = 0, m_steps = 0, m_sweeps = 0;
  int idle_coil [2] = '{0, 0};
  int ph [8] = '{1, 3, 2, 6, 4, 12, 8, 9};

  always #5 clk = ~clk;

  stepper_sweep_ctrl #(.STEP_DIV(DIV), .STEP_W(8), .SWEEP_W(4), .HOLD_TORQUE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .mode_i(mode), .dir_i(dir),
    .steps_i(steps), .sweeps_i(sweeps), .busy_o(busy[0]), .done_o(done[0]), .coil_o(coil[0]),
    .step_pos_o(pos[0]));
  stepper_sweep_ctrl #(.STEP_DIV(DIV), .STEP_W(8), .SWEEP_W(4), .HOLD_TORQUE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .mode_i(mode), .dir_i(dir),
    .steps_i(steps), .sweeps_i(sweeps), .busy_o(busy[1]), .done_o(done[1]), .coil_o(coil[1]),
    .step_pos_o(pos[1]));

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // coil pattern after k advances: direction flips every m_steps advances
  function automatic int pat_after(input int k);
    int idx = (m_mode == 1) ? 1 : 0;
    int inc = (m_mode == 2) ? 1 : 2;
    for (int a = 0; a < k; a++) begin
      if ((m_dir ^ ((a / m_steps) % 2)) != 0) idx = (idx + inc) % 8;
      else idx = (idx + 8 - inc) % 8;
    end
    return ph[idx];
  endfunction

  task automatic model_edge(input logic st, input logic sp);
    if (mst != 0 && sp) begin
      mst = 0;
      idle_coil = '{0, 0};
    end else if (mst == 0) begin
      if (st && !sp) begin
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        m_dir = int'(dir);
        m_steps = int'(steps);
        m_sweeps = int'(sweeps);
        j = 0;
        mst = (m_steps == 0 || m_sweeps == 0) ? 2 : 1;
      end
    end else if (mst == 1) begin
      j++;
      if (j > m_steps * m_sweeps * DIV) begin
        mst = 0;
        idle_coil[0] = 0;
        idle_coil[1] = pat_after(m_steps * m_sweeps);
      end
    end else mst = 0;
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      int eb = 0, ed = 0, ec = idle_coil[d], ep = 0;
      if (mst == 2) ed = 1;
      if (mst == 1) begin
        int k = j / DIV;
        ec = pat_after(k);
        eb = (k < m_steps * m_sweeps) ? 1 : 0;
        ed = (k == m_steps * m_sweeps) ? 1 : 0;
        ep = k % m_steps;
      end
      check($sformatf("busy%0d", d), int'(busy[d]), eb);
      check($sformatf("done%0d", d), int'(done[d]), ed);
      check($sformatf("coil%0d", d), int'(coil[d]), ec);
      check($sformatf("pos%0d", d), int'(pos[d]), ep);
    end
  endtask

  task automatic cyc(input logic st, input logic sp);
    start = st;
    stop = sp;
    @(posedge clk);
    model_edge(st, sp);
    #1;
    compare_all();
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic cfg(input int md, input int dr, input int st, input int sw);
    mode = 2'(md);
    dir = 1'(dr);
    steps = 8'(st);
    sweeps = 4'(sw);
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), int'(busy[d]), 0);
      check($sformatf("rst_done%0d", d), int'(done[d]), 0);
      check($sformatf("rst_coil%0d", d), int'(coil[d]), 0);
      check($sformatf("rst_pos%0d", d), int'(pos[d]), 0);
    end
    mst = 0;
    idle_coil = '{0, 0};
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #12;
    compare_all();
    rst_n = 1'b1;
    run(2);
    cfg(1, 1, 8, 1);
    cyc(1'b1, 1'b0);
    run(7);
    async_reset();
    cfg(0, 1, 4, 1);
    cyc(1'b1, 1'b0);
    run(20);
    cfg(2, 0, 3, 2);
    cyc(1'b1, 1'b0);
    run(28);
    cfg(1, 1, 5, 1);
    cyc(1'b1, 1'b0);
    run(9);
    cyc(1'b0, 1'b1);
    run(6);
    cfg(0, 1, 0, 3);
    cyc(1'b1, 1'b0);
    run(4);
    cfg(3, 0, 3, 2);
    cyc(1'b1, 1'b1);
    run(2);
    cyc(1'b1, 1'b0);
    run(5);
    cfg(2, 1, 6, 3);
    cyc(1'b1, 1'b0);
    run(20);
    for (int r = 0; r < 40; r++) begin
      cfg($urandom_range(3), $urandom_range(1), $urandom_range(6), $urandom_range(3));
      cyc(1'b1, $urandom_range(7) == 0);
      for (int c = 0, n = $urandom_range(90, 5); c < n; c++) begin
        cfg($urandom_range(3), $urandom_range(1), $urandom_range(6), $urandom_range(3));
        cyc($urandom_range(9) == 0, $urandom_range(59) == 0);
      end
      if ($urandom_range(9) == 0) async_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
